imem_fetch_ctrl: RTL and testbench

IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

---
 rtl/imem_fetch_ctrl_pkg.sv | 28 ++
 rtl/imem_addr_check.sv | 21 ++
 rtl/imem_fetch_ctrl.sv | 86 ++++++++
 tb/tb_imem_fetch_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
package imem_fetch_ctrl_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP            = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEF_RESET_PC   = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEF_EXC_VECTOR = 32'h8000_0008;
  localparam int unsigned     DEF_IMEM_WORDS = 256;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } state_t;

  // Fetch-to-decode output register payload
  typedef struct packed {
    logic            valid;
    logic            fault;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_out_t;

  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/imem_addr_check.sv
// Combinational alignment and range check of a fetch address.
module imem_addr_check
  import imem_fetch_ctrl_pkg::*;
#(
  parameter int unsigned IMEM_WORDS = DEF_IMEM_WORDS
) (
  input  logic [30:0] addr,
  output logic        fault_c
);

  // Wide compare so any IMEM_WORDS value fits without truncation
  localparam logic [32:0] WORDS = 33'(IMEM_WORDS);

  logic misaligned_c;
  logic out_of_range_c;

  assign misaligned_c   = (addr[1:0] != 2'b00);
  assign out_of_range_c = (33'(addr[30:2]) >= WORDS);
  assign fault_c        = misaligned_c | out_of_range_c;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: PC register, one-entry output register to
// decode, redirect/exception steering and a delivered-instruction counter.
module imem_fetch_ctrl
  import imem_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR,
  parameter int unsigned IMEM_WORDS = DEF_IMEM_WORDS
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        exc_req,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_fault,
  output logic [31:0] fetch_count
);

  state_t          state_q;
  logic [XLEN-1:0] pc_q;
  fetch_out_t      out_q;
  logic [31:0]     count_q;

  logic pc_fault_c;
  logic hold_c;
  logic deliver_c;

  imem_addr_check #(
    .IMEM_WORDS (IMEM_WORDS)
  ) u_addr_check (
    .addr    (pc_q[30:0]),
    .fault_c (pc_fault_c)
  );

  assign hold_c    = out_q.valid & ~id_ready;
  assign deliver_c = out_q.valid & id_ready & ~redirect_valid & ~exc_req;

  // Priority per edge: reset > exception > redirect > hold > sequential
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      out_q   <= '0;
      count_q <= '0;
    end else begin
      if (deliver_c) begin
        count_q <= count_q + 32'd1;
      end

      if (exc_req) begin
        state_q     <= RUN;
        pc_q        <= EXC_VECTOR;
        out_q.valid <= 1'b0;
      end else if (redirect_valid) begin
        state_q     <= RUN;
        pc_q        <= redirect_target;
        out_q.valid <= 1'b0;
      end else if (!hold_c) begin
        if (state_q == FAULT) begin
          // Fault word accepted (or already gone); PC stays frozen
          out_q.valid <= 1'b0;
        end else if (pc_fault_c) begin
          out_q   <= '{valid: 1'b1, fault: 1'b1, pc: pc_q, instr: NOP};
          state_q <= FAULT;
        end else begin
          out_q <= '{valid: 1'b1, fault: 1'b0, pc: pc_q, instr: imem_instr};
          pc_q  <= next_pc(pc_q);
        end
      end
    end
  end

  assign imem_addr   = pc_q;
  assign if_valid    = out_q.valid;
  assign if_pc       = out_q.pc;
  assign if_instr    = out_q.instr;
  assign if_fault    = out_q.fault;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Scoreboard bench for imem_fetch_ctrl: directed stimulus pushes expected
// deliveries; a negedge monitor pops and compares each accepted word.
module tb_imem_fetch_ctrl;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
    logic [31:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        exc_req;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_fault;
  logic [31:0] fetch_count;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  assign imem_instr = mem_word(imem_addr);

  imem_fetch_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .imem_addr       (imem_addr),
    .imem_instr      (imem_instr),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .exc_req         (exc_req),
    .id_ready        (id_ready),
    .if_valid        (if_valid),
    .if_pc           (if_pc),
    .if_instr        (if_instr),
    .if_fault        (if_fault),
    .fetch_count     (fetch_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] instr,
                      input logic fault, input logic [31:0] cnt);
    exp_t e;
    e.pc = pc; e.instr = instr; e.fault = fault; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(if_valid), 32'd0);
    check({tag, "_pc"}, if_pc, 32'd0);
    check({tag, "_instr"}, if_instr, 32'd0);
    check({tag, "_fault"}, 32'(if_fault), 32'd0);
    check({tag, "_count"}, fetch_count, 32'd0);
    check({tag, "_imem_addr"}, imem_addr, 32'h0000_0000);
  endtask

  // Monitor: every delivery to decode must match the head of the scoreboard
  always @(negedge clk) begin
    if (!reset && if_valid && id_ready && !redirect_valid && !exc_req) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_delivery: got pc %h expected none", if_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_pc", if_pc, e.pc);
        check("sb_instr", if_instr, e.instr);
        check("sb_fault", 32'(if_fault), 32'(e.fault));
        check("sb_count", fetch_count, e.cnt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; id_ready = 1'b1; redirect_valid = 1'b0;
    redirect_target = 32'h0; exc_req = 1'b0;
    step(); step();
    check_reset_outputs("rst0");

    // Straight-line fetch from RESET_PC
    push(32'h0, mem_word(32'h0), 1'b0, 32'd0);
    push(32'h4, mem_word(32'h4), 1'b0, 32'd1);
    push(32'h8, mem_word(32'h8), 1'b0, 32'd2);
    push(32'hC, mem_word(32'hC), 1'b0, 32'd3);
    reset = 1'b0;
    step();
    check("first_pc", if_pc, 32'h0);
    check("first_valid", 32'(if_valid), 32'd1);
    step(); step(); step(); step();
    id_ready = 1'b0;
    check("seq_count4", fetch_count, 32'd4);
    check("seq_pc16", if_pc, 32'h10);

    // Hold at if_pc=8, then run to count 7 and reset mid-hold
    reset = 1'b1;
    step();
    check_reset_outputs("rst1");
    for (int i = 0; i < 7; i++) push(32'(i * 4), mem_word(32'(i * 4)), 1'b0, 32'(i));
    reset = 1'b0; id_ready = 1'b1;
    step(); step(); step();
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_pc", if_pc, 32'h8);
      check("hold_imem_addr", imem_addr, 32'hC);
      check("hold_count", fetch_count, 32'd2);
    end
    id_ready = 1'b1;
    step();
    check("resume_pc", if_pc, 32'hC);
    step(); step(); step(); step();
    id_ready = 1'b0;
    step();
    check("hold7_count", fetch_count, 32'd7);
    check("hold7_pc", if_pc, 32'h1C);
    reset = 1'b1;
    step();
    check_reset_outputs("rst_hold");

    // Redirect while if_pc=4 costs one bubble and squashes word 4
    push(32'h0, mem_word(32'h0), 1'b0, 32'd0);
    push(32'hC, mem_word(32'hC), 1'b0, 32'd1);
    reset = 1'b0; id_ready = 1'b1;
    step();
    check("rd_imem_addr4", imem_addr, 32'h4);
    step();
    redirect_valid = 1'b1; redirect_target = 32'h0000_000C;
    step();
    redirect_valid = 1'b0;
    check("rd_bubble", 32'(if_valid), 32'd0);
    check("rd_imem_addr", imem_addr, 32'hC);
    check("rd_count", fetch_count, 32'd1);
    step();
    check("rd_pc", if_pc, 32'hC);
    check("rd_valid", 32'(if_valid), 32'd1);
    step();
    id_ready = 1'b0;
    check("rd_count2", fetch_count, 32'd2);

    // Misaligned redirect enters FAULT; exception recovers
    push(32'h402, 32'h0, 1'b1, 32'd2);
    redirect_valid = 1'b1; redirect_target = 32'h0000_0402; id_ready = 1'b1;
    step();
    redirect_valid = 1'b0; id_ready = 1'b0;
    check("mis_bubble", 32'(if_valid), 32'd0);
    check("mis_imem_addr", imem_addr, 32'h402);
    step();
    check("mis_fault", 32'(if_fault), 32'd1);
    check("mis_instr", if_instr, 32'h0);
    check("mis_pc", if_pc, 32'h402);
    step();
    check("mis_hold_fault", 32'(if_fault), 32'd1);
    check("mis_hold_valid", 32'(if_valid), 32'd1);
    check("mis_hold_addr", imem_addr, 32'h402);
    id_ready = 1'b1;
    step();
    check("mis_acc_count", fetch_count, 32'd3);
    check("mis_acc_valid", 32'(if_valid), 32'd0);
    step();
    check("fault_frozen_addr", imem_addr, 32'h402);
    check("fault_frozen_valid", 32'(if_valid), 32'd0);
    push(32'h8000_0008, mem_word(32'h8000_0008), 1'b0, 32'd3);
    exc_req = 1'b1;
    step();
    exc_req = 1'b0;
    check("exc_bubble", 32'(if_valid), 32'd0);
    check("exc_imem_addr", imem_addr, 32'h8000_0008);
    step();
    check("exc_pc", if_pc, 32'h8000_0008);
    check("exc_fault", 32'(if_fault), 32'd0);
    step();
    id_ready = 1'b0;
    check("exc_count", fetch_count, 32'd4);

    // Simultaneous redirect and exception: exception wins
    redirect_valid = 1'b1; redirect_target = 32'h0000_0040; exc_req = 1'b1;
    step();
    redirect_valid = 1'b0; exc_req = 1'b0; id_ready = 1'b1;
    check("both_imem_addr", imem_addr, 32'h8000_0008);
    check("both_valid", 32'(if_valid), 32'd0);
    check("both_count", fetch_count, 32'd4);
    push(32'h8000_0008, mem_word(32'h8000_0008), 1'b0, 32'd4);
    step();
    check("both_pc", if_pc, 32'h8000_0008);
    step();
    id_ready = 1'b0;
    check("both_count5", fetch_count, 32'd5);
    step();
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
